// File: rtl/pixel_readout_seq_pkg.sv
// Shared types and defaults for the photodiode readout sequencer.
package pixel_readout_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRst,
    StInt,
    StSh,
    StCmp,
    StNext
  } state_e;

  localparam int unsigned N_PIX_DEF = 12;
  localparam int unsigned TW_DEF    = 16;
  localparam int unsigned CMP_CYC   = 3;

endpackage

// File: rtl/cmp_sync.sv
// Two-flop synchronizer bringing the analog comparator output into the clock domain.
module cmp_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pixel_readout_seq.sv
// Per-channel reset/integrate/sample-hold/compare sequencer for a photodiode array.
module pixel_readout_seq
  import pixel_readout_seq_pkg::*;
#(
  parameter int unsigned N_PIX = N_PIX_DEF,
  parameter int unsigned TW    = TW_DEF
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             start,
  input  logic [N_PIX-1:0] pix_mask,
  input  logic [TW-1:0]    t_rst,
  input  logic [TW-1:0]    t_int,
  input  logic [TW-1:0]    t_sh,
  input  logic             cmp,
  output logic [N_PIX-1:0] pd_a,
  output logic [N_PIX-1:0] pd_b,
  output logic             sh_rst,
  output logic             sw1,
  output logic             sh,
  output logic             sw2,
  output logic             sh_cmp,
  output logic             busy,
  output logic             done,
  output logic [N_PIX-1:0] result
);

  localparam int unsigned IW = (N_PIX > 1) ? $clog2(N_PIX) : 1;

  state_e           state_q, state_d;
  logic [TW-1:0]    cnt_q, cnt_d;
  logic [TW-1:0]    t_rst_q, t_rst_d, t_int_q, t_int_d, t_sh_q, t_sh_d;
  logic [N_PIX-1:0] rem_q, rem_d, result_q, result_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             done_q, done_d;
  logic             cmp_s;

  logic [TW-1:0]    len_rst, len_int, len_sh;
  logic             found;
  logic [IW-1:0]    first;

  cmp_sync u_cmp_sync (
    .clk_i (wb_clk_i),
    .rst_i (wb_rst_i),
    .d_i   (cmp),
    .q_o   (cmp_s)
  );

  // Zero-length phases still occupy one cycle.
  assign len_rst = (t_rst_q == '0) ? TW'(1) : t_rst_q;
  assign len_int = (t_int_q == '0) ? TW'(1) : t_int_q;
  assign len_sh  = (t_sh_q  == '0) ? TW'(1) : t_sh_q;

  // Lowest channel still pending; the scan consumes rem_q one bit at a time.
  always_comb begin
    found = 1'b0;
    first = '0;
    for (int i = int'(N_PIX) - 1; i >= 0; i--) begin
      if (rem_q[i]) begin
        found = 1'b1;
        first = IW'(i);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    t_rst_d  = t_rst_q;
    t_int_d  = t_int_q;
    t_sh_d   = t_sh_q;
    rem_d    = rem_q;
    idx_d    = idx_q;
    result_d = result_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          t_rst_d  = t_rst;
          t_int_d  = t_int;
          t_sh_d   = t_sh;
          rem_d    = pix_mask;
          result_d = '0;
          cnt_d    = '0;
          state_d  = StNext;
        end
      end
      StRst: begin
        if (cnt_q == len_rst - TW'(1)) begin
          cnt_d   = '0;
          state_d = StInt;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      StInt: begin
        if (cnt_q == len_int - TW'(1)) begin
          cnt_d   = '0;
          state_d = StSh;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      StSh: begin
        if (cnt_q == len_sh - TW'(1)) begin
          cnt_d   = '0;
          state_d = StCmp;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      StCmp: begin
        if (cnt_q == TW'(CMP_CYC - 1)) begin
          result_d[idx_q] = cmp_s;
          cnt_d           = '0;
          state_d         = StNext;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      StNext: begin
        cnt_d = '0;
        if (found) begin
          idx_d        = first;
          rem_d[first] = 1'b0;
          state_d      = StRst;
        end else begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      t_rst_q  <= '0;
      t_int_q  <= '0;
      t_sh_q   <= '0;
      rem_q    <= '0;
      idx_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      t_rst_q  <= t_rst_d;
      t_int_q  <= t_int_d;
      t_sh_q   <= t_sh_d;
      rem_q    <= rem_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  // Switch drives decode straight from registered state; NEXT and IDLE leave all open.
  always_comb begin
    pd_a   = '0;
    pd_b   = '0;
    sh_rst = 1'b0;
    sw1    = 1'b0;
    sh     = 1'b0;
    sw2    = 1'b0;
    sh_cmp = 1'b0;
    unique case (state_q)
      StRst: begin
        pd_a   = N_PIX'(1) << idx_q;
        sh_rst = 1'b1;
      end
      StInt: begin
        pd_a = N_PIX'(1) << idx_q;
        sw1  = 1'b1;
      end
      StSh: begin
        pd_a = N_PIX'(1) << idx_q;
        sh   = 1'b1;
        sw2  = 1'b1;
      end
      StCmp: begin
        pd_b   = N_PIX'(1) << idx_q;
        sh_cmp = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy   = (state_q != StIdle);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_pixel_readout_seq.sv
// Directed self-checking bench for pixel_readout_seq with the default 12-channel configuration.
module tb_pixel_readout_seq;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        start;
  logic [11:0] pix_mask;
  logic [15:0] t_rst, t_int, t_sh;
  logic        cmp;
  logic [11:0] pd_a, pd_b, result;
  logic        sh_rst, sw1, sh, sw2, sh_cmp, busy, done;

  int vectors     = 0;
  int miscompares = 0;

  // Per-frame observations gathered by run_frame.
  int          done_at, busy_len, rst_cyc, int_cyc, sh_cyc, cmp_cyc;
  int          overlap_err, ctrl_err, done_busy_err;
  int          pa_cnt[12];
  int          pb_cnt[12];
  int          visit_q[$];
  logic [11:0] res_first;

  always #5 wb_clk_i = ~wb_clk_i;

  pixel_readout_seq dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .start    (start),
    .pix_mask (pix_mask),
    .t_rst    (t_rst),
    .t_int    (t_int),
    .t_sh     (t_sh),
    .cmp      (cmp),
    .pd_a     (pd_a),
    .pd_b     (pd_b),
    .sh_rst   (sh_rst),
    .sw1      (sw1),
    .sh       (sh),
    .sw2      (sw2),
    .sh_cmp   (sh_cmp),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  task automatic step();
    @(posedge wb_clk_i);
    #1;
  endtask

  // Starts one frame and watches it to done; cmp follows cmp_pat for whichever channel is selected.
  task automatic run_frame(input logic [11:0] mask, input logic [15:0] tr, input logic [15:0] ti,
                           input logic [15:0] ts, input logic [11:0] cmp_pat, input int budget,
                           input int repulse_at);
    logic [11:0] prev_pa;
    done_at = -1; busy_len = 0; rst_cyc = 0; int_cyc = 0; sh_cyc = 0; cmp_cyc = 0;
    overlap_err = 0; ctrl_err = 0; done_busy_err = 0;
    for (int i = 0; i < 12; i++) begin
      pa_cnt[i] = 0;
      pb_cnt[i] = 0;
    end
    visit_q.delete();
    pix_mask = mask; t_rst = tr; t_int = ti; t_sh = ts;
    start = 1'b1;
    step();
    start = 1'b0;
    res_first = result;
    prev_pa = '0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (done) begin
        done_at = cyc;
        if (busy) done_busy_err++;
        break;
      end
      if (busy) busy_len++;
      if ($countones(pd_a | pd_b) > 1 || (pd_a & pd_b) != 0) overlap_err++;
      for (int i = 0; i < 12; i++) begin
        if (pd_a[i]) begin
          pa_cnt[i]++;
          if (!prev_pa[i]) begin
            visit_q.push_back(i);
            cmp = cmp_pat[i];
          end
        end
        if (pd_b[i]) pb_cnt[i]++;
      end
      if (pd_a != 0) begin
        if (!({sh_rst, sw1, sh, sw2, sh_cmp} inside {5'b10000, 5'b01000, 5'b00110})) ctrl_err++;
      end else if (pd_b != 0) begin
        if ({sh_rst, sw1, sh, sw2, sh_cmp} != 5'b00001) ctrl_err++;
      end else if ({sh_rst, sw1, sh, sw2, sh_cmp} != 5'b00000) begin
        ctrl_err++;
      end
      rst_cyc += int'(sh_rst);
      int_cyc += int'(sw1);
      sh_cyc  += int'(sh);
      cmp_cyc += int'(sh_cmp);
      prev_pa = pd_a;
      start = (cyc == repulse_at);
      if (start) begin
        t_int    = 16'd9;
        pix_mask = 12'hFFF;
      end
      step();
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    wb_rst_i = 1'b1;
    step();
    step();
    vectors++;
    if ({pd_a, pd_b} !== 24'h0) begin
      miscompares++; $display("FAIL reset_sel: got %h want 0", {pd_a, pd_b});
    end
    vectors++;
    if ({sh_rst, sw1, sh, sw2, sh_cmp} !== 5'b0) begin
      miscompares++; $display("FAIL reset_ctrl: got %b want 0", {sh_rst, sw1, sh, sw2, sh_cmp});
    end
    vectors++;
    if ({busy, done, result} !== 14'h0) begin
      miscompares++; $display("FAIL reset_status: got %h want 0", {busy, done, result});
    end
    wb_rst_i = 1'b0;
    step();
  endtask

  task automatic test_single();
    run_frame(12'h001, 16'd2, 16'd4, 16'd2, 12'hFFF, 100, -1);
    vectors++;
    if (done_at != 13) begin miscompares++; $display("FAIL single_done_at: got %0d want 13", done_at); end
    vectors++;
    if (busy_len != 13) begin miscompares++; $display("FAIL single_busy: got %0d want 13", busy_len); end
    vectors++;
    if (pa_cnt[0] != 8) begin miscompares++; $display("FAIL single_pd_a: got %0d want 8", pa_cnt[0]); end
    vectors++;
    if (pb_cnt[0] != 3) begin miscompares++; $display("FAIL single_pd_b: got %0d want 3", pb_cnt[0]); end
    vectors++;
    if ({rst_cyc, int_cyc, sh_cyc, cmp_cyc} != {32'd2, 32'd4, 32'd2, 32'd3}) begin
      miscompares++;
      $display("FAIL single_phases: got %0d/%0d/%0d/%0d want 2/4/2/3", rst_cyc, int_cyc, sh_cyc, cmp_cyc);
    end
    vectors++;
    if (result !== 12'h001) begin miscompares++; $display("FAIL single_result: got %h want 001", result); end
    vectors++;
    if (ctrl_err + overlap_err + done_busy_err != 0) begin
      miscompares++;
      $display("FAIL single_ctrl: got %0d/%0d/%0d errors want 0", ctrl_err, overlap_err, done_busy_err);
    end
  endtask

  task automatic test_full_scan();
    int ordbad;
    run_frame(12'hFFF, 16'd1, 16'd1, 16'd1, 12'h555, 300, -1);
    vectors++;
    if (res_first !== 12'h000) begin
      miscompares++; $display("FAIL scan_clear: got %h want 000", res_first);
    end
    vectors++;
    if (done_at != 85) begin miscompares++; $display("FAIL scan_done_at: got %0d want 85", done_at); end
    vectors++;
    if (result !== 12'h555) begin miscompares++; $display("FAIL scan_result: got %h want 555", result); end
    ordbad = 0;
    for (int i = 0; i < visit_q.size(); i++) if (visit_q[i] != i) ordbad++;
    vectors++;
    if (visit_q.size() != 12 || ordbad != 0) begin
      miscompares++;
      $display("FAIL scan_order: got %0d visits %0d misordered want 12 / 0", visit_q.size(), ordbad);
    end
    vectors++;
    if (overlap_err != 0) begin miscompares++; $display("FAIL scan_overlap: got %0d want 0", overlap_err); end
    vectors++;
    if (ctrl_err != 0) begin miscompares++; $display("FAIL scan_ctrl: got %0d want 0", ctrl_err); end
  endtask

  task automatic test_empty_mask();
    run_frame(12'h000, 16'd3, 16'd3, 16'd3, 12'hFFF, 20, -1);
    vectors++;
    if (done_at != 1) begin miscompares++; $display("FAIL empty_done_at: got %0d want 1", done_at); end
    vectors++;
    if (busy_len != 1) begin miscompares++; $display("FAIL empty_busy: got %0d want 1", busy_len); end
    vectors++;
    if (result !== 12'h000) begin miscompares++; $display("FAIL empty_result: got %h want 000", result); end
    vectors++;
    if (done_busy_err != 0) begin miscompares++; $display("FAIL empty_done_busy: got %0d want 0", done_busy_err); end
  endtask

  task automatic test_sparse();
    run_frame(12'h810, 16'd0, 16'd0, 16'd0, 12'hFFF, 100, -1);
    vectors++;
    if (done_at != 15) begin miscompares++; $display("FAIL sparse_done_at: got %0d want 15", done_at); end
    vectors++;
    if (visit_q.size() != 2 || visit_q[0] != 4 || visit_q[1] != 11) begin
      miscompares++; $display("FAIL sparse_visits: got %0d visits want channels 4,11", visit_q.size());
    end
    vectors++;
    if ({pa_cnt[4], pa_cnt[11], pb_cnt[4], pb_cnt[11]} != {32'd3, 32'd3, 32'd3, 32'd3}) begin
      miscompares++;
      $display("FAIL sparse_len: got %0d/%0d/%0d/%0d want 3/3/3/3", pa_cnt[4], pa_cnt[11], pb_cnt[4], pb_cnt[11]);
    end
    vectors++;
    if (result !== 12'h810) begin miscompares++; $display("FAIL sparse_result: got %h want 810", result); end
  endtask

  task automatic test_result_hold();
    int busy_seen;
    busy_seen = 0;
    for (int i = 0; i < 6; i++) begin
      cmp = ~cmp;
      pix_mask = 12'h3C3 ^ 12'(i);
      step();
      if (busy) busy_seen++;
    end
    vectors++;
    if (result !== 12'h810) begin miscompares++; $display("FAIL hold_result: got %h want 810", result); end
    vectors++;
    if (busy_seen != 0) begin miscompares++; $display("FAIL hold_busy: got %0d want 0", busy_seen); end
  endtask

  task automatic test_restart_ignored();
    run_frame(12'h001, 16'd2, 16'd4, 16'd2, 12'h000, 100, 5);
    vectors++;
    if (done_at != 13) begin miscompares++; $display("FAIL restart_done_at: got %0d want 13", done_at); end
    vectors++;
    if (int_cyc != 4) begin miscompares++; $display("FAIL restart_int: got %0d want 4", int_cyc); end
    vectors++;
    if (visit_q.size() != 1) begin miscompares++; $display("FAIL restart_visits: got %0d want 1", visit_q.size()); end
    vectors++;
    if (result !== 12'h000) begin miscompares++; $display("FAIL restart_result: got %h want 000", result); end
    step();
    step();
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL restart_idle: got %b want 0", busy); end
  endtask

  task automatic test_max_len();
    run_frame(12'h001, 16'hFFFF, 16'd0, 16'd0, 12'h001, 70000, -1);
    vectors++;
    if (done_at != 65542) begin miscompares++; $display("FAIL max_done_at: got %0d want 65542", done_at); end
    vectors++;
    if (rst_cyc != 65535) begin miscompares++; $display("FAIL max_rst: got %0d want 65535", rst_cyc); end
    vectors++;
    if (result !== 12'h001) begin miscompares++; $display("FAIL max_result: got %h want 001", result); end
  endtask

  task automatic test_reset_mid();
    bit found;
    int done_seen, busy_seen;
    cmp = 1'b1;
    pix_mask = 12'hFFF; t_rst = 16'd1; t_int = 16'd1; t_sh = 16'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    found = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (pd_a[3] && sw1) begin
        found = 1'b1;
        break;
      end
      step();
    end
    vectors++;
    if (!found) begin miscompares++; $display("FAIL rstmid_reach: got no ch3 INT want ch3 INT"); end
    wb_rst_i = 1'b1;
    step();
    vectors++;
    if ({pd_a, pd_b} !== 24'h0) begin
      miscompares++; $display("FAIL rstmid_sel: got %h want 0", {pd_a, pd_b});
    end
    vectors++;
    if ({sh_rst, sw1, sh, sw2, sh_cmp} !== 5'b0) begin
      miscompares++; $display("FAIL rstmid_ctrl: got %b want 0", {sh_rst, sw1, sh, sw2, sh_cmp});
    end
    vectors++;
    if ({busy, done, result} !== 14'h0) begin
      miscompares++; $display("FAIL rstmid_status: got %h want 0", {busy, done, result});
    end
    wb_rst_i = 1'b0;
    done_seen = 0;
    busy_seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done) done_seen++;
      if (busy) busy_seen++;
    end
    vectors++;
    if (done_seen != 0 || busy_seen != 0) begin
      miscompares++; $display("FAIL rstmid_after: got done %0d busy %0d want 0/0", done_seen, busy_seen);
    end
  endtask

  initial begin
    wb_rst_i = 1'b1;
    start    = 1'b0;
    cmp      = 1'b0;
    pix_mask = '0;
    t_rst    = '0;
    t_int    = '0;
    t_sh     = '0;
    test_reset();
    test_single();
    test_full_scan();
    test_empty_mask();
    test_sparse();
    test_result_hold();
    test_restart_ignored();
    test_max_len();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
